// File: rtl/mvm_uart_sequencer_if.sv
// mvm_uart_sequencer_if: UART byte, MVM K/x/y and status signals of the sequencer.
// Rev 1.0
`default_nettype none

interface mvm_uart_sequencer_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_BUS_KX      = 24,
  parameter int W_Y_BUS       = 18
);
  logic                     s_rx_valid;
  logic [BITS_PER_WORD-1:0] s_rx_data;
  logic                     m_mvm_valid;
  logic                     m_mvm_ready;
  logic [W_BUS_KX-1:0]      m_mvm_kx;
  logic                     s_y_valid;
  logic                     s_y_ready;
  logic [W_Y_BUS-1:0]       s_y_data;
  logic                     m_tx_valid;
  logic                     m_tx_ready;
  logic [BITS_PER_WORD-1:0] m_tx_data;
  logic                     busy;
  logic                     overrun;
  logic                     frame_drop;

  // master is the sequencer's own view; slave is the surrounding system
  modport master (
    input  s_rx_valid, s_rx_data, m_mvm_ready, s_y_valid, s_y_data, m_tx_ready,
    output m_mvm_valid, m_mvm_kx, s_y_ready, m_tx_valid, m_tx_data, busy, overrun, frame_drop
  );
  modport slave (
    output s_rx_valid, s_rx_data, m_mvm_ready, s_y_valid, s_y_data, m_tx_ready,
    input  m_mvm_valid, m_mvm_kx, s_y_ready, m_tx_valid, m_tx_data, busy, overrun, frame_drop
  );
endinterface

`default_nettype wire

// File: rtl/mvm_uart_sequencer.sv
// mvm_uart_sequencer: assembles UART bytes into a K/x bus, issues it to the MVM, streams truncated y back.
// Rev 1.0
`default_nettype none

module mvm_uart_sequencer #(
  parameter int R              = 2,
  parameter int C              = 2,
  parameter int W_X            = 4,
  parameter int W_K            = 4,
  parameter int W_Y_OUT        = 8,
  parameter int BITS_PER_WORD  = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  mvm_uart_sequencer_if.master bus
);
  localparam int W_Y        = W_X + W_K + $clog2(C);
  localparam int W_BUS_KX   = R*C*W_K + C*W_X;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int N_WORDS_Y  = R*W_Y_OUT / BITS_PER_WORD;
  localparam int CW         = $clog2(N_WORDS_KX + 1);
  localparam int TW         = $clog2(N_WORDS_Y + 1);
  localparam int TOW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_RX    = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_TX    = 2'd3;

  if (W_BUS_KX % BITS_PER_WORD != 0) begin : g_err_kx_width
    $error("W_BUS_KX must be a multiple of BITS_PER_WORD");
  end
  if ((R*W_Y_OUT) % BITS_PER_WORD != 0) begin : g_err_y_width
    $error("R*W_Y_OUT must be a multiple of BITS_PER_WORD");
  end

  logic [1:0]               state;
  logic [CW-1:0]            cnt;
  logic [TOW-1:0]           idle_cnt;
  logic [W_BUS_KX-1:0]      kx;
  logic [R*W_Y_OUT-1:0]     tx_buf;
  logic [TW-1:0]            tx_idx;
  logic                     overrun_q;
  logic                     drop_q;
  logic [BITS_PER_WORD-1:0] tx_word;

  always_comb begin
    tx_word = '0;
    for (int i = 0; i < N_WORDS_Y; i++) begin
      if (tx_idx == TW'(i)) tx_word = tx_buf[i*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  assign bus.m_mvm_valid = (state == ST_ISSUE);
  assign bus.m_mvm_kx    = kx;
  assign bus.s_y_ready   = (state == ST_WAIT);
  assign bus.m_tx_valid  = (state == ST_TX);
  assign bus.m_tx_data   = (state == ST_TX) ? tx_word : '0;
  assign bus.busy        = (state != ST_RX);
  assign bus.overrun     = overrun_q;
  assign bus.frame_drop  = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RX;
      cnt       <= '0;
      idle_cnt  <= '0;
      kx        <= '0;
      tx_buf    <= '0;
      tx_idx    <= '0;
      overrun_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (bus.s_rx_valid && state != ST_RX) overrun_q <= 1'b1;
      case (state)
        ST_RX: begin
          // a strobe always beats a coincident timeout
          if (bus.s_rx_valid) begin
            for (int i = 0; i < N_WORDS_KX; i++) begin
              if (cnt == CW'(i)) kx[i*BITS_PER_WORD +: BITS_PER_WORD] <= bus.s_rx_data;
            end
            idle_cnt <= '0;
            if (cnt == CW'(N_WORDS_KX - 1)) begin
              cnt   <= '0;
              state <= ST_ISSUE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (cnt != '0) begin
            if (idle_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
              cnt      <= '0;
              idle_cnt <= '0;
              drop_q   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.m_mvm_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.s_y_valid) begin
            for (int r = 0; r < R; r++) begin
              tx_buf[r*W_Y_OUT +: W_Y_OUT] <= bus.s_y_data[r*W_Y +: W_Y_OUT];
            end
            tx_idx <= '0;
            state  <= ST_TX;
          end
        end
        ST_TX: begin
          if (bus.m_tx_ready) begin
            if (tx_idx == TW'(N_WORDS_Y - 1)) begin
              tx_idx <= '0;
              cnt    <= '0;
              state  <= ST_RX;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mvm_uart_sequencer.sv
// tb_mvm_uart_sequencer: directed frames with a queue scoreboard on the MVM and TX handshakes.
// Rev 1.0
`default_nettype none

module tb_mvm_uart_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvm_uart_sequencer_if #(.BITS_PER_WORD(8), .W_BUS_KX(24), .W_Y_BUS(18)) bus ();

  mvm_uart_sequencer #(
    .R(2), .C(2), .W_X(4), .W_K(4), .W_Y_OUT(8), .BITS_PER_WORD(8), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int kx_hs = 0;
  int tx_hs = 0;
  logic [23:0] exp_kx[$];
  logic [7:0]  exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.s_rx_valid = 1'b1;
    bus.s_rx_data  = b;
    tick();
    bus.s_rx_valid = 1'b0;
    bus.s_rx_data  = '0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic give_y(input logic [17:0] y);
    bus.s_y_valid = 1'b1;
    bus.s_y_data  = y;
    tick();
    bus.s_y_valid = 1'b0;
  endtask

  task automatic drain_tx(input bit toggle, input string name);
    int n = 0;
    bus.m_tx_ready = toggle ? 1'b0 : 1'b1;
    while (bus.busy && n < 50) begin
      tick();
      if (toggle) bus.m_tx_ready = ~bus.m_tx_ready;
      n++;
    end
    bus.m_tx_ready = 1'b0;
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  logic       prev_txv = 1'b0;
  logic       prev_txr = 1'b0;
  logic [7:0] prev_txd = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.m_mvm_valid && bus.m_mvm_ready) begin
          kx_hs++;
          if (exp_kx.size() == 0) check("kx_unexpected", 32'd1, 32'd0);
          else check("kx", {8'd0, bus.m_mvm_kx}, {8'd0, exp_kx.pop_front()});
        end
        if (bus.m_tx_valid && bus.m_tx_ready) begin
          tx_hs++;
          if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
          else check("tx_byte", {24'd0, bus.m_tx_data}, {24'd0, exp_tx.pop_front()});
        end
        if (prev_txv && !prev_txr) begin
          check("tx_hold_valid", {31'd0, bus.m_tx_valid}, 32'd1);
          check("tx_hold_data", {24'd0, bus.m_tx_data}, {24'd0, prev_txd});
        end
        prev_txv = bus.m_tx_valid;
        prev_txr = bus.m_tx_ready;
        prev_txd = bus.m_tx_data;
      end else begin
        prev_txv = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    bus.s_rx_valid  = 1'b0;
    bus.s_rx_data   = '0;
    bus.m_mvm_ready = 1'b0;
    bus.s_y_valid   = 1'b0;
    bus.s_y_data    = '0;
    bus.m_tx_ready  = 1'b0;
    tick();
    tick();
    check("rst_outputs", {bus.m_mvm_valid, bus.s_y_ready, bus.m_tx_valid, bus.busy,
                          bus.overrun, bus.frame_drop}, 32'd0);
    check("rst_kx", {8'd0, bus.m_mvm_kx}, 32'd0);
    check("rst_txd", {24'd0, bus.m_tx_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: x=[5,6], K=[[1,2],[3,4]]
    exp_kx.push_back(24'h432165);
    send_byte(8'h65);
    send_byte(8'h21);
    check("valid_early", {31'd0, bus.m_mvm_valid}, 32'd0);
    send_byte(8'h43);
    check("valid_after_last", {31'd0, bus.m_mvm_valid}, 32'd1);
    check("busy_issue", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("issue_hold_valid", {31'd0, bus.m_mvm_valid}, 32'd1);
      check("issue_hold_kx", {8'd0, bus.m_mvm_kx}, 32'h432165);
    end
    bus.m_mvm_ready = 1'b1;
    tick();
    bus.m_mvm_ready = 1'b0;
    check("y_ready_rise", {31'd0, bus.s_y_ready}, 32'd1);
    check("valid_dropped", {31'd0, bus.m_mvm_valid}, 32'd0);
    check("kx_hs_once", kx_hs, 32'd1);

    // Byte strobed while waiting for the result is dropped as overrun
    send_byte(8'hAA);
    check("overrun_set", {31'd0, bus.overrun}, 32'd1);
    check("still_wait", {31'd0, bus.s_y_ready}, 32'd1);

    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h27);
    give_y({9'd39, 9'd17});
    drain_tx(1'b1, "idle_after_tx1");
    check("overrun_sticky", {31'd0, bus.overrun}, 32'd1);

    // Frame 2: truncation of -3 and 256
    exp_kx.push_back(24'h543210);
    send_frame(8'h10, 8'h32, 8'h54);
    bus.m_mvm_ready = 1'b1;
    tick();
    bus.m_mvm_ready = 1'b0;
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hFD);
    give_y({9'h1FD, 9'h100});
    drain_tx(1'b0, "idle_after_tx2");

    // Partial frame timeout, then a clean frame
    send_byte(8'h77);
    send_byte(8'h88);
    drops = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.frame_drop) drops++;
    end
    check("frame_drop_once", drops, 32'd1);
    check("busy_after_drop", {31'd0, bus.busy}, 32'd0);
    exp_kx.push_back(24'h452301);
    send_frame(8'h01, 8'h23, 8'h45);
    check("valid_after_drop", {31'd0, bus.m_mvm_valid}, 32'd1);
    bus.m_mvm_ready = 1'b1;
    tick();
    bus.m_mvm_ready = 1'b0;

    // Reset in the middle of TX
    give_y({9'd39, 9'd17});
    tick();
    check("tx_pending_valid", {31'd0, bus.m_tx_valid}, 32'd1);
    check("tx_pending_data", {24'd0, bus.m_tx_data}, 32'h11);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {bus.m_mvm_valid, bus.s_y_ready, bus.m_tx_valid, bus.busy,
                              bus.overrun, bus.frame_drop}, 32'd0);
    check("rst_mid_txd", {24'd0, bus.m_tx_data}, 32'd0);
    check("rst_mid_kx", {8'd0, bus.m_mvm_kx}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    check("kx_queue_empty", exp_kx.size(), 32'd0);
    check("tx_queue_empty", exp_tx.size(), 32'd0);
    check("kx_hs_total", kx_hs, 32'd3);
    check("tx_hs_total", tx_hs, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
